eth_vlg_tx_arb: RTL
===================

// Module: eth_vlg_tx_arb
// PURPOSE
//  N-channel transmit arbiter/mux between protocol engines (ICMP, UDP, TCP, ...) and the shared IPv4/MAC tx path.
//  Successor of the fixed 3-way tx mux: parametrised channel count and meta width, selectable fixed-priority
//  or round-robin arbitration, per-packet lock, registered stream path and a lock watchdog with error pulse.
// PARAMETERS
//  N             4       number of source channels, 2..16
//  W             64      meta width in bits (e.g. $bits(ipv4_meta_t))
//  MODE          ARB_PRIO  arb_mode_t: ARB_PRIO (lowest index wins) or ARB_RR (round-robin)
//  TIMEOUT_TICKS 100000  max cycles a grant may stay locked without done_mux; 0 disables watchdog
// PORTS
//  clk        in   1     system clock
//  rst        in   1     synchronous active-high reset
//  meta       in   N*W   per-channel meta, channel i at [i*W +: W], valid while rdy[i]
//  rdy        in   N     channel i has a packet pending; held until done[i] or abandon
//  req        out  N     grant-forwarded request: req[sel] = req_mux, others 0
//  acc        out  N     acc[sel] = acc_mux, others 0
//  done       out  N     1-cycle pulse to granted channel on done_mux
//  dat        in   N*8   per-channel stream byte
//  val/sof/eof in  N     per-channel stream qualifiers
//  meta_mux   out  W     latched meta of granted channel
//  dat_mux    out  8     muxed stream byte, registered
//  val_mux/sof_mux/eof_mux out 1 each  muxed qualifiers, registered
//  rdy_mux    out  1     packet pending downstream
//  req_mux    in   1     downstream requests stream
//  acc_mux    in   1     downstream accepted packet
//  done_mux   in   1     downstream finished packet
//  sel        out  $clog2(N) index of granted channel (valid while busy)
//  busy       out  1     grant locked
//  timeout    out  1     1-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, RR pointer 0, watchdog 0. Reset mid-packet drops grant with no done pulse.
//  FSM IDLE -> GRANT -> PEND -> XFER -> IDLE.
//   IDLE: if |rdy at cycle t, pick winner; sel, meta_mux latched, busy=1, state GRANT at t+1.
//   GRANT/PEND: rdy_mux=1 from t+1; req[sel]/acc[sel] follow req_mux/acc_mux combinationally; on acc_mux -> XFER.
//   XFER: stream of sel registered to *_mux outputs, 1-cycle latency; non-selected streams ignored.
//    done_mux -> done[sel] pulse same cycle (combinational), rdy_mux=0 and busy=0 next cycle, state IDLE.
//  Abandon: rdy[sel] falls in GRANT/PEND before acc_mux -> IDLE next cycle, no done pulse, RR pointer unchanged.
//   rdy[sel] falling during XFER is ignored (lock holds until done_mux).
//  Arbitration ARB_PRIO: lowest set index of rdy wins. ARB_RR: first set index at or after ptr (wrapping N-1->0);
//   ptr <= sel+1 (mod N) on done_mux only. Single requester wins immediately in both modes.
//  Minimum one IDLE cycle between packets; back-to-back rdy from same channel re-arbitrates against others.
//  Watchdog: counts cycles while busy, clears on entering IDLE; at TIMEOUT_TICKS-1 -> timeout pulse, done[sel]
//   NOT pulsed, grant dropped, IDLE next cycle, ptr advanced as if done (prevents lock-up by a dead channel).
//  done_mux and timeout same cycle: done wins, no timeout pulse.
//  Counter width $clog2(TIMEOUT_TICKS+1); no wrap possible.
//  req_mux/acc_mux/done_mux in IDLE are ignored; req/acc/done all 0.
// STRUCTURE
//  eth_vlg_pkg: typedef enum {ARB_PRIO, ARB_RR} arb_mode_t; typedef enum {IDLE,GRANT,PEND,XFER} arb_fsm_t.
//  Sub-module eth_vlg_arb_pick: combinational winner select (rdy, ptr, mode -> idx, vld); reused by rx demux later.
//  ipv4_vlg_top replaces its tx mux with this block, N=3, MODE=ARB_RR.
// TESTING
//  1 Reset: hold rst 3 cycles mid-XFER -> all outputs 0, busy=0, no done pulse; rdy=3'b010 after -> sel=1.
//  2 PRIO N=3: rdy=3'b111 repeatedly, done_mux after 10 bytes each -> grants 0,0,0...; channel 2 starved.
//  3 RR N=3: rdy=3'b111 held, 3 packets -> sel 0,1,2 then 0; meta_mux equals meta slice of sel each grant.
//  4 Stream: 64-byte packet on ch1, dat 0x00..0x3F -> dat_mux identical 1 cycle later, sof/eof aligned, ch0/ch2 noise absent.
//  5 Abandon: ch2 granted, rdy[2] drops before acc_mux -> IDLE next cycle, done=0, next grant by arbitration.
//  6 Watchdog TIMEOUT_TICKS=50: acc_mux, no done_mux -> timeout pulse at busy cycle 50, done=0, RR ptr advanced.

Source files
------------

// File: rtl/eth_vlg_pkg.sv
// Shared types for the eth_vlg transmit/receive arbitration blocks.
// Arbitration mode and arbiter FSM state encodings.
package eth_vlg_pkg;

  typedef enum logic {
    ARB_PRIO,
    ARB_RR
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    PEND,
    XFER
  } arb_fsm_t;

endpackage

// File: rtl/eth_vlg_arb_pick.sv
// Combinational winner select over N request lines.
// Fixed priority (lowest index) or round-robin starting at ptr.
module eth_vlg_arb_pick
  import eth_vlg_pkg::*;
#(
  parameter int N = 4
)(
  input  logic [N-1:0]         rdy,
  input  logic [$clog2(N)-1:0] ptr,
  input  arb_mode_t            mode,
  output logic [$clog2(N)-1:0] idx,
  output logic                 vld
);

  localparam int IW = $clog2(N);

  // scan from the start point, first pending channel wins
  always_comb begin
    int j;
    idx = '0;
    vld = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      if (mode == ARB_RR) j = (int'(ptr) + k) % N;
      else j = k;
      if (!vld && rdy[j]) begin
        idx = IW'(j);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_vlg_tx_arb.sv
// N-channel transmit arbiter/mux in front of the shared IPv4/MAC tx path.
// Per-packet lock, registered stream path, lock watchdog with error pulse.
module eth_vlg_tx_arb
  import eth_vlg_pkg::*;
#(
  parameter int        N             = 4,
  parameter int        W             = 64,
  parameter arb_mode_t MODE          = ARB_PRIO,
  parameter int        TIMEOUT_TICKS = 100000
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       meta,
  input  logic [N-1:0]         rdy,
  output logic [N-1:0]         req,
  output logic [N-1:0]         acc,
  output logic [N-1:0]         done,
  input  logic [N*8-1:0]       dat,
  input  logic [N-1:0]         val,
  input  logic [N-1:0]         sof,
  input  logic [N-1:0]         eof,
  output logic [W-1:0]         meta_mux,
  output logic [7:0]           dat_mux,
  output logic                 val_mux,
  output logic                 sof_mux,
  output logic                 eof_mux,
  output logic                 rdy_mux,
  input  logic                 req_mux,
  input  logic                 acc_mux,
  input  logic                 done_mux,
  output logic [$clog2(N)-1:0] sel,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = $clog2(N);
  localparam int CW =
    (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT_TICKS > 0) ? CW'(TIMEOUT_TICKS - 1) : '0;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  arb_fsm_t        r_state;
  arb_fsm_t        w_nxt;
  logic [IW-1:0]   r_sel;
  logic [IW-1:0]   r_ptr;
  logic [W-1:0]    r_meta;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_dat;
  logic            r_val;
  logic            r_sof;
  logic            r_eof;
  logic [IW-1:0]   w_idx;
  logic            w_vld;
  logic            w_busy;
  logic            w_hold;
  logic            w_done;
  logic            w_to;
  logic            w_aband;

  eth_vlg_arb_pick #(.N(N)) u_pick (
    .rdy  (rdy),
    .ptr  (r_ptr),
    .mode (MODE),
    .idx  (w_idx),
    .vld  (w_vld)
  );

  assign w_busy  = (r_state != IDLE);
  assign w_hold  = (r_state == GRANT) || (r_state == PEND);
  assign w_done  = (r_state == XFER) && done_mux;
  assign w_aband = w_hold && !rdy[r_sel];
  assign w_to    = (TIMEOUT_TICKS > 0) && w_busy &&
                   (r_cnt == TO_LAST) && !w_done;

  // next state: grant, wait for accept, stream until done
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_vld) w_nxt = GRANT;
      GRANT: begin
        if (w_aband) w_nxt = IDLE;
        else if (acc_mux) w_nxt = XFER;
        else if (req_mux) w_nxt = PEND;
      end
      PEND: begin
        if (w_aband) w_nxt = IDLE;
        else if (acc_mux) w_nxt = XFER;
      end
      XFER:  if (w_done) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_to) w_nxt = IDLE;
  end

  // forward handshake lines to the granted channel only
  always_comb begin
    req = '0;
    acc = '0;
    done = '0;
    if (w_busy) begin
      req[r_sel] = req_mux;
      acc[r_sel] = acc_mux;
    end
    done[r_sel] = w_done;
  end

  // state, grant latch and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
      r_meta  <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == IDLE && w_vld) begin
        r_sel  <= w_idx;
        r_meta <= meta[w_idx*W +: W];
      end
      if (w_done || w_to)
        r_ptr <= (r_sel == LAST) ? '0 : r_sel + 1'b1;
    end
  end

  // watchdog counts busy cycles, zero on entering idle
  always_ff @(posedge clk) begin
    if (rst) r_cnt <= '0;
    else if (w_busy && w_nxt != IDLE) r_cnt <= r_cnt + 1'b1;
    else r_cnt <= '0;
  end

  // registered stream path from the granted channel
  always_ff @(posedge clk) begin
    if (rst || r_state != XFER) begin
      r_dat <= '0;
      r_val <= 1'b0;
      r_sof <= 1'b0;
      r_eof <= 1'b0;
    end else begin
      r_dat <= dat[r_sel*8 +: 8];
      r_val <= val[r_sel];
      r_sof <= sof[r_sel];
      r_eof <= eof[r_sel];
    end
  end

  assign sel      = r_sel;
  assign busy     = w_busy;
  assign rdy_mux  = w_busy;
  assign timeout  = w_to;
  assign meta_mux = r_meta;
  assign dat_mux  = r_dat;
  assign val_mux  = r_val;
  assign sof_mux  = r_sof;
  assign eof_mux  = r_eof;

endmodule
